eth_axis_echo_responder: RTL
============================

Name: eth_axis_echo_responder

Overview:
Logic-side peer of the 1G RGMII MAC AXI-stream interface: consumes the MAC receive stream and drives the MAC transmit stream. Each good received frame is stored in a single frame buffer, its Ethernet header is rewritten (destination = original source, source = LOCAL_MAC), and it is sent back. Runs in the MAC logic clock domain (125 MHz) and serves as a link bring-up/loopback responder.

Parameters:
ADDR_WIDTH, 11, frame buffer address width; capacity 2**ADDR_WIDTH bytes
LOCAL_MAC, 48'h02_00_00_00_00_01, source MAC inserted on echo; byte 0 = bits [47:40]
MATCH_DEST, 1, 1 = echo only if dest equals LOCAL_MAC or FF:FF:FF:FF:FF:FF; 0 = echo all

Ports:
clk  in  1  logic clock; all logic is rising-edge
rst  in  1  synchronous reset, active high
enable  in  1  0 = drop every newly starting frame
rx_axis_tdata  in  8  receive byte from MAC
rx_axis_tvalid  in  1  receive beat valid; no ready, every beat must be taken
rx_axis_tlast  in  1  last byte of frame
rx_axis_tuser  in  1  with tlast: frame bad (FCS/error)
tx_axis_tdata  out  8  transmit byte to MAC
tx_axis_tvalid  out  1  transmit beat valid
tx_axis_tready  in  1  MAC accepts beat
tx_axis_tlast  out  1  last byte of echoed frame
tx_axis_tuser  out  1  always 0
busy  out  1  buffer holds a frame awaiting/under transmission
echo_count  out  16  frames echoed (counted on tx tlast handshake), saturating
drop_count  out  16  frames dropped, saturating

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0; buffer contents don't-care. Reset mid-frame abandons both sides; the remainder of an in-flight rx frame is dropped (rx in_frame flag cleared, next beat without preceding tlast treated as frame start → see discard rule below is not applied; frame start = first valid beat after reset or after a tlast beat).
- Frame start decision (first beat): accept if FSM = IDLE and enable = 1, else mark frame DISCARD; DISCARD frames increment drop_count once, at their tlast.
- RECV: write byte to mem[wr_ptr], wr_ptr++. Byte counter is ADDR_WIDTH+1 bits.
- Drop at tlast (drop_count++, return IDLE, no tx) if: tuser = 1; length < 14; length > 2**ADDR_WIDTH (overflow: writes stop at full, flag sticky); MATCH_DEST = 1 and bytes 0–5 neither LOCAL_MAC nor all-FF (compared on the fly, per-byte flags).
- Good tlast: store length, FSM → TX, busy = 1 in the next cycle.
- TX: synchronous-read RAM, one-beat prefetch/skid register; tx_axis_tvalid first asserts exactly 2 cycles after the accepting rx tlast beat. Output byte i: i 0–5 → mem[i+6]; i 6–11 → LOCAL_MAC byte (i-6); i ≥ 12 → mem[i]. tlast on byte length-1.
- AXI rules: once tvalid = 1, tdata/tlast held stable until tready; no bubbles while tready is high (one byte per cycle sustained). tready may toggle arbitrarily.
- On tlast handshake: echo_count++, FSM → IDLE, busy = 0 next cycle. A frame whose first beat coincides with that handshake cycle is dropped (FSM not yet IDLE).
- Frames starting during TX are discarded whole, even if TX ends mid-frame.
- Counters saturate at 16'hFFFF. Single-byte frames (first beat has tlast) are runts → drop.

Test Plan:
- 64-byte good frame, dest = LOCAL_MAC, src = 00:11:22:33:44:55, tready = 1 → tvalid 2 cycles after rx tlast; tx bytes 0–5 = 00:11:22:33:44:55, 6–11 = 02:00:00:00:00:01, bytes 12–63 identical, tlast on byte 63, echo_count = 1.
- Same frame with tuser = 1 on tlast → no tx beats, drop_count = 1, busy stays 0.
- Second 60-byte frame starting while first is echoed with tready toggling 1/0 each cycle → first frame intact and stable under backpressure, second dropped, drop_count = 1.
- MATCH_DEST = 1, dest = 02:00:00:00:00:99 → dropped; dest = FF:FF:FF:FF:FF:FF → echoed.
- ADDR_WIDTH = 6, 65-byte frame → dropped; 13-byte frame → dropped; 64-byte frame → echoed.
- Assert rst at rx byte 30 of a frame, release → no tx from that frame; next good frame echoes correctly, counters restarted from 0.

Source files
------------

// File: rtl/eth_axis_echo_responder.sv
// eth_axis_echo_responder
//
// Loopback responder that sits on the logic side of a 1G MAC AXI-stream pair.
// It stores each good received frame in a single buffer. It then sends the
// frame back with the Ethernet addresses rewritten:
//   - destination = original source
//   - source      = LOCAL_MAC
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   enable            0 = every newly starting frame is dropped
//   rx_axis_*         receive stream from the MAC (no backpressure possible)
//   tx_axis_*         transmit stream to the MAC (tuser always 0)
//   busy              buffer holds a frame awaiting or under transmission
//   echo_count        frames echoed, saturating
//   drop_count        frames dropped, saturating
module eth_axis_echo_responder #(
    parameter int          ADDR_WIDTH = 11,
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
    parameter bit          MATCH_DEST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  rx_axis_tdata,
    input  logic        rx_axis_tvalid,
    input  logic        rx_axis_tlast,
    input  logic        rx_axis_tuser,
    output logic [7:0]  tx_axis_tdata,
    output logic        tx_axis_tvalid,
    input  logic        tx_axis_tready,
    output logic        tx_axis_tlast,
    output logic        tx_axis_tuser,
    output logic        busy,
    output logic [15:0] echo_count,
    output logic [15:0] drop_count
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    typedef logic [LEN_W-1:0] len_t;

    localparam len_t DEPTH    = len_t'(1) << ADDR_WIDTH;
    localparam len_t MIN_LEN  = len_t'(14);
    localparam len_t DEST_END = len_t'(6);
    localparam len_t SRC_END  = len_t'(12);

    typedef enum logic [1:0] {IDLE, RECV, TX} state_t;

    state_t state;

    logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [7:0] rd_data;

    // Receive-side tracking.
    logic rx_in_frame;
    logic rx_ovf;
    logic rx_match_local;
    logic rx_match_bcast;
    len_t rx_len;

    // Transmit-side tracking.
    // s1 is the RAM output stage; the tx_axis registers form the second stage.
    len_t tx_len;
    len_t fetch_idx;
    len_t s1_idx;
    logic s1_valid;

    logic rx_start;
    logic rx_take;
    logic at_full;
    logic wr_en;
    logic ovf_next;
    logic match_local_next;
    logic match_bcast_next;
    logic dest_ok;
    logic good_accept;
    logic drop_event;
    logic tx_end;
    logic s2_load;
    logic s1_free;
    logic rd_en;
    len_t cur_len;
    len_t len_next;
    len_t rd_idx;
    len_t hdr_idx;
    logic [ADDR_WIDTH-1:0] rd_addr;

    function automatic logic [7:0] mac_byte(input len_t i);
        logic [7:0] b;
        case (i)
            len_t'(0): b = LOCAL_MAC[47:40];
            len_t'(1): b = LOCAL_MAC[39:32];
            len_t'(2): b = LOCAL_MAC[31:24];
            len_t'(3): b = LOCAL_MAC[23:16];
            len_t'(4): b = LOCAL_MAC[15:8];
            default:   b = LOCAL_MAC[7:0];
        endcase
        return b;
    endfunction

    // Per-beat receive decisions.
    // A frame is only taken when it starts while the buffer is free, and then
    // every one of its beats is taken. Destination matching runs on the fly,
    // so the verdict is ready on the tlast beat itself. The first header read
    // is launched on that same beat, which is what keeps the echo latency at
    // two cycles.
    always_comb begin
        rx_start         = !rx_in_frame;
        cur_len          = rx_start ? '0 : rx_len;
        rx_take          = 1'b0;
        if (rx_axis_tvalid) begin
            rx_take = rx_start ? (state == IDLE && enable) : (state == RECV);
        end
        at_full          = (cur_len == DEPTH);
        wr_en            = rx_take && !at_full;
        len_next         = at_full ? cur_len : cur_len + len_t'(1);
        ovf_next         = (!rx_start && rx_ovf) || at_full;
        match_local_next = (rx_start || rx_match_local) &&
                           (cur_len >= DEST_END || rx_axis_tdata == mac_byte(cur_len));
        match_bcast_next = (rx_start || rx_match_bcast) &&
                           (cur_len >= DEST_END || rx_axis_tdata == 8'hFF);
        dest_ok          = !MATCH_DEST || match_local_next || match_bcast_next;
        good_accept      = rx_take && rx_axis_tlast && !rx_axis_tuser &&
                           (len_next >= MIN_LEN) && !ovf_next && dest_ok;
        drop_event       = rx_axis_tvalid && rx_axis_tlast && !good_accept;

        tx_end           = tx_axis_tvalid && tx_axis_tready && tx_axis_tlast;
        s2_load          = s1_valid && (!tx_axis_tvalid || tx_axis_tready);
        s1_free          = !s1_valid || s2_load;
        rd_idx           = good_accept ? '0 : fetch_idx;
        rd_en            = good_accept ||
                           (state == TX && fetch_idx != tx_len && s1_free);
        rd_addr          = (rd_idx < DEST_END) ?
                           rd_idx[ADDR_WIDTH-1:0] + ADDR_WIDTH'(6) :
                           rd_idx[ADDR_WIDTH-1:0];
        hdr_idx          = s1_idx - DEST_END;
    end

    // Frame buffer.
    // Plain write port plus a registered read port. The read data only updates
    // on a read, so a stalled s1 stage keeps its byte.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cur_len[ADDR_WIDTH-1:0]] <= rx_axis_tdata;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    assign tx_axis_tuser = 1'b0;

    // Control FSM, two-stage transmit pipeline and counters.
    // The output register reloads whenever it is empty or being accepted.
    // That keeps the data stable under backpressure and allows one byte per
    // cycle while tready stays high. Header bytes 6..11 are substituted
    // with LOCAL_MAC here, so the RAM read issued for them is simply ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rx_in_frame    <= 1'b0;
            rx_len         <= '0;
            rx_ovf         <= 1'b0;
            rx_match_local <= 1'b0;
            rx_match_bcast <= 1'b0;
            tx_len         <= '0;
            fetch_idx      <= '0;
            s1_idx         <= '0;
            s1_valid       <= 1'b0;
            tx_axis_tdata  <= '0;
            tx_axis_tvalid <= 1'b0;
            tx_axis_tlast  <= 1'b0;
            busy           <= 1'b0;
            echo_count     <= '0;
            drop_count     <= '0;
        end else begin
            if (rx_axis_tvalid) begin
                rx_in_frame <= !rx_axis_tlast;
            end
            if (rx_take) begin
                rx_len         <= len_next;
                rx_ovf         <= ovf_next;
                rx_match_local <= match_local_next;
                rx_match_bcast <= match_bcast_next;
            end

            if (good_accept) begin
                state  <= TX;
                busy   <= 1'b1;
                tx_len <= len_next;
            end else begin
                case (state)
                    IDLE: if (rx_take && !rx_axis_tlast) state <= RECV;
                    RECV: if (rx_take && rx_axis_tlast)  state <= IDLE;
                    TX: begin
                        if (tx_end) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (rd_en) begin
                fetch_idx <= rd_idx + len_t'(1);
                s1_idx    <= rd_idx;
                s1_valid  <= 1'b1;
            end else if (s2_load) begin
                s1_valid  <= 1'b0;
            end

            if (!tx_axis_tvalid || tx_axis_tready) begin
                tx_axis_tvalid <= s1_valid;
                if (s1_valid) begin
                    tx_axis_tdata <= (s1_idx >= DEST_END && s1_idx < SRC_END) ?
                                     mac_byte(hdr_idx) : rd_data;
                    tx_axis_tlast <= (s1_idx == tx_len - len_t'(1));
                end else begin
                    tx_axis_tlast <= 1'b0;
                end
            end

            if (tx_end && echo_count != 16'hFFFF) begin
                echo_count <= echo_count + 16'd1;
            end
            if (drop_event && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule
